// File: rtl/vga_timing_pkg.sv
// Shared types and timing constants for the VGA raster engine.
// Holds standard mode timings, FSM encoding and sizing helpers.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } span_t;

  // 640x480@60 with a 25.175 MHz pixel clock
  localparam span_t H_640X480 = '{640, 16, 96, 48};
  localparam span_t V_640X480 = '{480, 10, 2, 33};

  // 800x600@60 with a 40 MHz pixel clock
  localparam span_t H_800X600 = '{800, 40, 128, 88};
  localparam span_t V_800X600 = '{600, 1, 4, 23};

  // Raster flags carried from the counter stage to the pins
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } raster_t;

  function automatic int span_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int fb_dim(
    input int act,
    input int sh
  );
    return act >> sh;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to INIT.
// Aligns sync, enable and strobe flags with framebuffer latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= INIT;
      end
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA raster generator with downscaled framebuffer
// addressing, read-latency compensation and frame-aligned start/stop.
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CH_W     = 4,
  parameter int SCALE_SH = 0,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              CLK_25_I,
  input  logic              RST_N_I,
  input  logic              ENABLE_I,
  input  logic [3*CH_W-1:0] VIDEO_PXL_I,
  output logic [CH_W-1:0]   RED_O,
  output logic [CH_W-1:0]   GREEN_O,
  output logic [CH_W-1:0]   BLUE_O,
  output logic              HSYNC_O,
  output logic              VSYNC_O,
  output logic              VIDEO_EN_O,
  output logic [ADDR_W-1:0] ADDRESS_O,
  output logic              FRAME_START_O,
  output logic              LINE_START_O,
  output logic              BUSY_O
);

  localparam int H_TOT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);
  localparam int FB_W  = fb_dim(H_ACTIVE, SCALE_SH);

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOT - 1);
  localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_C = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_MSK   = V_W'((1 << SCALE_SH) - 1);
  localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(FB_W);

  localparam raster_t R_IDLE = '{
    hs: ~HS_POL,
    vs: ~VS_POL,
    de: 1'b0,
    fs: 1'b0,
    ls: 1'b0
  };

  state_t            state;
  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic [H_W-1:0]    col;
  logic [ADDR_W-1:0] row_base;
  logic              running;
  logic              h_end;
  logic              v_end;
  logic              frame_end;
  logic              act;
  logic              row_done;
  raster_t           r_now;
  raster_t           r_q;
  raster_t           r_out;

  assign running   = (state != ST_IDLE);
  assign h_end     = (h == H_LAST);
  assign v_end     = (v == V_LAST);
  assign frame_end = h_end && v_end;
  assign act       = running && (h < H_ACT_C) && (v < V_ACT_C);
  assign col       = h >> SCALE_SH;
  assign row_done  = h_end && (v < V_ACT_C)
                  && ((v & V_MSK) == V_MSK);

  // Stopping only takes effect at a frame boundary
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ENABLE_I) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!ENABLE_I) begin
            state <= frame_end ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ENABLE_I) state <= ST_RUN;
          else if (frame_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (running) begin
        h <= h_end ? '0 : h + H_W'(1);
        if (h_end) begin
          v <= v_end ? '0 : v + V_W'(1);
        end
      end
    end
  end

  always_comb begin
    r_now    = R_IDLE;
    r_now.de = act;
    r_now.fs = act && (h == '0) && (v == '0);
    r_now.ls = act && (h == '0);
    if (running && (h >= HS_BEG) && (h < HS_END)) begin
      r_now.hs = HS_POL;
    end
    if (running && (v >= VS_BEG) && (v < VS_END)) begin
      r_now.vs = VS_POL;
    end
  end

  // Row base advances once per replicated group of lines
  always_ff @(posedge CLK_25_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_q       <= R_IDLE;
      row_base  <= '0;
      ADDRESS_O <= '0;
    end else begin
      r_q <= r_now;
      if (act) begin
        ADDRESS_O <= row_base + ADDR_W'(col);
      end
      if (frame_end) begin
        row_base <= '0;
      end else if (row_done) begin
        row_base <= row_base + FB_STEP;
      end
    end
  end

  vga_delay_line #(
    .WIDTH($bits(raster_t)),
    .DEPTH(RD_LAT),
    .INIT (R_IDLE)
  ) u_align (
    .clk  (CLK_25_I),
    .rst_n(RST_N_I),
    .d    (r_q),
    .q    (r_out)
  );

  assign HSYNC_O       = r_out.hs;
  assign VSYNC_O       = r_out.vs;
  assign VIDEO_EN_O    = r_out.de;
  assign FRAME_START_O = r_out.fs;
  assign LINE_START_O  = r_out.ls;
  assign BUSY_O        = running;

  assign RED_O   = VIDEO_EN_O ? VIDEO_PXL_I[3*CH_W-1:2*CH_W] : '0;
  assign GREEN_O = VIDEO_EN_O ? VIDEO_PXL_I[2*CH_W-1:CH_W]   : '0;
  assign BLUE_O  = VIDEO_EN_O ? VIDEO_PXL_I[CH_W-1:0]        : '0;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a 16x8 raster, 2x downscale,
// one-cycle framebuffer; frame-position model plus literal checks.
module tb_vga_timing_engine;

  localparam int HA = 8;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int FT = 128;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] pxl;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, de;
  logic [3:0]  addr;
  logic        fs, ls, busy;
  logic        force_ff;
  logic [3:0]  pa;

  int total = 0;
  int bad = 0;

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(4),
    .SCALE_SH(1), .RD_LAT(1), .ADDR_W(4)
  ) dut (
    .CLK_25_I     (clk),
    .RST_N_I      (rst_n),
    .ENABLE_I     (en),
    .VIDEO_PXL_I  (pxl),
    .RED_O        (red),
    .GREEN_O      (green),
    .BLUE_O       (blue),
    .HSYNC_O      (hsync),
    .VSYNC_O      (vsync),
    .VIDEO_EN_O   (de),
    .ADDRESS_O    (addr),
    .FRAME_START_O(fs),
    .LINE_START_O (ls),
    .BUSY_O       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input int a);
    logic [11:0] r;
    r = 12'(a * 37 + 5);
    return r ^ 12'hA5C;
  endfunction

  // Framebuffer with one cycle of read latency
  always @(posedge clk) begin
    pxl <= force_ff ? 12'hFFF : pix(int'(addr));
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: raster position within the frame plus a running flag
  typedef struct {
    bit busy;
    int pos;
  } snap_t;

  snap_t sn [3];
  int    e_addr;

  function automatic snap_t adv(input snap_t s, input bit go);
    snap_t r;
    r = s;
    if (!s.busy) begin
      if (go) begin
        r.busy = 1'b1;
        r.pos  = 0;
      end
    end else begin
      r.pos  = (s.pos + 1) % FT;
      r.busy = !((s.pos == FT - 1) && !go);
    end
    return r;
  endfunction

  function automatic bit m_act(input snap_t s);
    return s.busy && (s.pos % HT < HA) && (s.pos / HT < VA);
  endfunction

  function automatic int m_addr(input snap_t s);
    return ((s.pos / HT) >> 1) * (HA >> 1) + ((s.pos % HT) >> 1);
  endfunction

  function automatic bit m_hs(input snap_t s);
    int h;
    h = s.pos % HT;
    return !(s.busy && h >= 10 && h < 13);
  endfunction

  function automatic bit m_vs(input snap_t s);
    int v;
    v = s.pos / HT;
    return !(s.busy && v >= 5 && v < 7);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sn[i] <= '{busy: 1'b0, pos: 0};
      end
      e_addr <= 0;
    end else begin
      sn[2] <= sn[1];
      sn[1] <= sn[0];
      if (m_act(sn[0])) e_addr <= m_addr(sn[0]);
      sn[0] <= adv(sn[0], en);
    end
  end

  always @(posedge clk) begin
    #2;
    check("hsync", int'(hsync), int'(m_hs(sn[2])));
    check("vsync", int'(vsync), int'(m_vs(sn[2])));
    check("video_en", int'(de), int'(m_act(sn[2])));
    check("frame_start", int'(fs),
          int'(m_act(sn[2]) && sn[2].pos == 0));
    check("line_start", int'(ls),
          int'(m_act(sn[2]) && sn[2].pos % HT == 0));
    check("busy", int'(busy), int'(sn[0].busy));
    check("address", int'(addr), e_addr);
    check("rgb", int'({red, green, blue}),
          !m_act(sn[2]) ? 0 :
          force_ff ? 'hFFF : int'(pix(m_addr(sn[2]))));
  end

  task automatic step();
    pa = addr;
    @(negedge clk);
  endtask

  int exp_seq [32] = '{0, 0, 1, 1, 2, 2, 3, 3,
                       0, 0, 1, 1, 2, 2, 3, 3,
                       4, 4, 5, 5, 6, 6, 7, 7,
                       4, 4, 5, 5, 6, 6, 7, 7};
  int seen [32];

  initial begin
    int n, na, cnt;
    int hs_lo, vs_lo, de_hi, fs_n, ls_n;
    bit low_seen;
    en       = 1'b0;
    force_ff = 1'b0;
    rst_n    = 1'b1;
    pa       = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_de", int'(de), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    repeat (5) step();
    check("idle_busy", int'(busy), 0);
    check("idle_hsync", int'(hsync), 1);

    en = 1'b1;
    n = 0;
    while (!fs && n < 20) begin
      step();
      n++;
    end
    check("fs_seen", int'(fs), 1);

    hs_lo = 0; vs_lo = 0; de_hi = 0;
    fs_n = 0; ls_n = 0; na = 0;
    for (int i = 0; i < FT; i++) begin
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
      if (fs) fs_n++;
      if (ls) ls_n++;
      if (de) begin
        if (na < 32) seen[na] = int'(pa);
        de_hi++;
        na++;
      end
      step();
    end
    check("hs_low_cycles", hs_lo, 24);
    check("vs_low_cycles", vs_lo, 32);
    check("de_cycles", de_hi, 32);
    check("fs_count", fs_n, 1);
    check("ls_count", ls_n, 4);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("addr_seq[%0d]", i), seen[i], exp_seq[i]);
    end
    check("next_fs", int'(fs), 1);

    repeat (40) step();
    en = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      step();
      cnt++;
    end
    check("stop_latency", cnt, 86);

    force_ff = 1'b1;
    repeat (4) step();
    check("idle_rgb_ff", int'({red, green, blue}), 0);
    check("idle_de_ff", int'(de), 0);

    en = 1'b1;
    n = 0;
    while (!fs && n < 20) begin
      step();
      n++;
    end
    check("fs_seen2", int'(fs), 1);
    repeat (40) step();
    en = 1'b0;
    repeat (30) step();
    en = 1'b1;
    cnt = 0;
    low_seen = 1'b0;
    while (!fs && cnt < 300) begin
      step();
      cnt++;
      if (!busy) low_seen = 1'b1;
    end
    check("restart_fs_gap", cnt, 58);
    check("restart_no_idle", int'(low_seen), 0);
    force_ff = 1'b0;

    n = 0;
    while (!de && n < 40) begin
      step();
      n++;
    end
    check("de_before_reset", int'(de), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hsync", int'(hsync), 1);
    check("arst_vsync", int'(vsync), 1);
    check("arst_de", int'(de), 0);
    check("arst_rgb", int'({red, green, blue}), 0);
    check("arst_addr", int'(addr), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_fs", int'(fs), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
